// File: rtl/wave_capture.sv
// Captures a zero-crossing-aligned window of audio samples into the back bank
// of a double-buffered display RAM, flipping banks only while the display is idle.
module wave_capture #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_sample_ready,
  input  logic [15:0]           new_sample_in,
  input  logic                  wave_display_idle,
  output logic                  write_enable,
  output logic [ADDR_WIDTH:0]   write_address,
  output logic [7:0]            write_sample,
  output logic                  read_index
);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  prev_neg_q;
  logic                  write_enable_q;
  logic [ADDR_WIDTH:0]   write_address_q;
  logic [7:0]            write_sample_q;
  logic                  read_index_q;

  logic                  trigger_d;
  logic [7:0]            write_sample_d;

  // Offset-binary top byte: flipping the sign bit maps -32768..32767 onto 0..255.
  assign write_sample_d = {~new_sample_in[15], new_sample_in[14:8]};
  assign trigger_d      = new_sample_ready && prev_neg_q && !new_sample_in[15];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_ARMED;
      count_q         <= '0;
      prev_neg_q      <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_sample_q  <= '0;
      read_index_q    <= 1'b0;
    end else begin
      write_enable_q <= 1'b0;
      if (new_sample_ready) begin
        prev_neg_q <= new_sample_in[15];
      end
      case (state_q)
        S_ARMED: begin
          if (trigger_d) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, {ADDR_WIDTH{1'b0}}};
            write_sample_q  <= write_sample_d;
            count_q         <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            state_q         <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (new_sample_ready) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, count_q};
            write_sample_q  <= write_sample_d;
            count_q         <= count_q + 1'b1;
            if (count_q == {ADDR_WIDTH{1'b1}}) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A sample arriving on the exit cycle only refreshes prev_neg_q.
          if (wave_display_idle) begin
            read_index_q <= ~read_index_q;
            state_q      <= S_ARMED;
          end
        end
        default: begin
          state_q <= S_ARMED;
        end
      endcase
    end
  end

  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;

endmodule

// File: doc/wave_capture.md
# wave_capture

Captures a window of the audio stream leaving `music_player` for the wave display. It watches each 16-bit sample as it is produced and arms on a rising zero crossing, so displayed waveforms start in phase and do not jitter. It then writes 2^ADDR_WIDTH consecutive samples into one half of an external double-buffered display RAM. It flips the buffer only when the display reports it is idle.

## Interface
- ADDR_WIDTH, 8, log2 of samples per capture window (one RAM bank)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- new_sample_ready  in  1  one-cycle pulse, driven from music_player `new_sample_generated`
- new_sample_in  in  16  signed two's-complement sample, valid when new_sample_ready is high
- wave_display_idle  in  1  level; high while the display is not reading RAM (blanking)
- write_enable  out  1  one-cycle RAM write strobe
- write_address  out  ADDR_WIDTH+1  {bank, index}; bank is always ~read_index
- write_sample  out  8  unsigned display sample
- read_index  out  1  bank the display reads

## Operation
- State machine has three states: ARMED, ACTIVE, WAIT. Reset state is ARMED.
- `prev_neg` register:
  - Holds the MSB of the last accepted sample.
  - Updates on every new_sample_ready, in all states.
  - Reset value is 0.
- Trigger rule: a rising crossing occurs when new_sample_ready=1 and prev_neg=1 and new_sample_in[15]=0. 0x0000 counts as non-negative.
- ARMED:
  - On a trigger, write the trigger sample at index 0, set count=1 and go to ACTIVE.
  - A sample with no trigger is not written.
- ACTIVE:
  - Each new_sample_ready writes at index count, then count increments modulo 2^ADDR_WIDTH.
  - The write at index 2^ADDR_WIDTH-1 moves the FSM to WAIT and leaves count at 0.
- WAIT:
  - Samples are ignored except for the prev_neg update.
  - When wave_display_idle=1, toggle read_index and go to ARMED.
  - If new_sample_ready coincides with the exit, that sample updates prev_neg but is not tested for a trigger.
- Sample conversion: write_sample = {~new_sample_in[15], new_sample_in[14:8]}. This is an offset-binary top byte, so 0x8000 maps to 0x00, 0x0000 to 0x80 and 0x7FFF to 0xFF.
- write_address = {~read_index, index}, which guarantees writes never hit the displayed bank.
- Exactly 2^ADDR_WIDTH writes occur per capture, each to a distinct index, in ascending order.
- wave_display_idle is ignored in ARMED and ACTIVE. The buffer never flips mid-capture.

## Timing
- All outputs are registered.
- Reset values: write_enable=0, write_address=0, write_sample=0, read_index=0; state is ARMED, count=0, prev_neg=0.
- Write latency:
  - write_enable pulses high for exactly one cycle, in the cycle after the new_sample_ready cycle that caused the write.
  - write_address and write_sample are valid in that same cycle.
  - write_address and write_sample hold their values until the next write.
- Flip latency: read_index toggles in the cycle after wave_display_idle is sampled high in WAIT. The first trigger after the flip is evaluated no earlier than the next new_sample_ready.
- Back-to-back new_sample_ready pulses, one every cycle, must each be accepted.
- Asynchronous reset assertion mid-capture:
  - Immediately returns the block to its reset values.
  - A partially written bank is abandoned; the next capture rewrites bank 1 from index 0.
- new_sample_in is sampled only when new_sample_ready is high; its value in all other cycles is don't-care.

## Test plan
- Reset then trigger:
  - Stimulus: release reset; pulse samples 0x0100, 0xFF00, 0x0200.
  - Response: no write for the first two samples. The third sample writes address 0x100 with write_sample=0x82, one cycle after its pulse.
- Full window (ADDR_WIDTH=8):
  - Stimulus: after a trigger, feed 300 samples with wave_display_idle=0.
  - Response: exactly 256 writes at addresses 0x100..0x1FF, then no writes; read_index stays 0.
- Flip:
  - Stimulus: in WAIT, raise wave_display_idle for 1 cycle.
  - Response: read_index becomes 1 on the next cycle. The next capture writes 0x000..0x0FF, starting only at the next negative-to-non-negative crossing.
- Conversion:
  - Stimulus: capture samples 0x8000, 0x7FFF, 0x0000, 0xC000.
  - Response: write_sample values are 0x00, 0xFF, 0x80, 0x40.
- Simultaneous events:
  - Stimulus: in WAIT, assert idle and new_sample_ready together with 0x0010 after prev_neg=1.
  - Response: no write; flip occurs; prev_neg=0.
- Reset mid-capture:
  - Stimulus: drop reset low after 100 writes.
  - Response: all outputs go to 0 asynchronously. After release, no writes occur until a new crossing; the first write goes to 0x100.
